// File: rtl/dff_readback_framer.sv
// ============================================================================
// dff_readback_framer
//
// Purpose:
//   Captures a wide parallel vector (for example the Q outputs of a DFF test
//   array) when trig is sampled high. The captured value is then sent out as
//   a byte frame over a valid/ready stream. The frame layout is:
//       HEADER, data byte 0 (LSB) .. data byte WIDTH/8-1, XOR checksum
//   The checksum is the XOR of the data bytes only. The header is not
//   included in the checksum.
//
// Ports:
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      synchronous reset, active-low
//   din        in   WIDTH  parallel vector to capture
//   trig       in   1      capture request, sampled every cycle
//   out_data   out  8      current frame byte (registered)
//   out_valid  out  1      out_data is valid (registered)
//   out_ready  in   1      sink accepts byte when out_valid && out_ready
//   busy       out  1      frame in progress (registered)
//   done       out  1      one-cycle pulse after the checksum is accepted
//   ovr        out  1      sticky: trig seen while busy, cleared on next capture
// ============================================================================
module dff_readback_framer #(
    parameter int         WIDTH  = 64,
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             trig,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             ovr
);

    localparam int NB = WIDTH / 8;
    localparam int IW = $clog2(NB) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);
    localparam logic [IW-1:0] ONE_IDX  = IW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_CSUM = 2'd3
    } state_t;

    // Byte idx of the captured vector. Byte 0 is the least-significant byte.
    function automatic logic [7:0] sel_byte(input logic [WIDTH-1:0] vec,
                                            input logic [IW-1:0]    idx);
        logic [WIDTH-1:0] sh;
        sh = vec >> {idx, 3'b000};
        return sh[7:0];
    endfunction

    // Running XOR checksum step.
    function automatic logic [7:0] csum_step(input logic [7:0] acc,
                                             input logic [7:0] data_byte);
        return acc ^ data_byte;
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] snap_q, snap_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [7:0]       csum_q, csum_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ovr_q, ovr_d;

    logic             accept_s;
    logic [IW-1:0]    nxt_idx_s;
    logic [7:0]       csum_nxt_s;

    // Next-state and output-register logic for the frame sequencer
    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        idx_d       = idx_q;
        csum_d      = csum_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ovr_d       = ovr_q;

        accept_s   = out_valid_q && out_ready;
        nxt_idx_s  = idx_q + ONE_IDX;
        csum_nxt_s = csum_step(csum_q, sel_byte(snap_q, idx_q));

        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    snap_d      = din;
                    csum_d      = 8'h00;
                    ovr_d       = 1'b0;
                    idx_d       = '0;
                    state_d     = ST_HDR;
                    out_valid_d = 1'b1;
                    out_data_d  = HEADER;
                    busy_d      = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            ST_HDR: begin
                if (accept_s) begin
                    state_d    = ST_DATA;
                    idx_d      = '0;
                    out_data_d = snap_q[7:0];
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_DATA: begin
                if (accept_s) begin
                    csum_d = csum_nxt_s;
                    // The last data byte goes straight to the checksum byte.
                    // The index stops at LAST_IDX and does not wrap.
                    if (idx_q == LAST_IDX) begin
                        state_d    = ST_CSUM;
                        out_data_d = csum_nxt_s;
                    end else begin
                        idx_d      = nxt_idx_s;
                        out_data_d = sel_byte(snap_q, nxt_idx_s);
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_CSUM: begin
                if (accept_s) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    out_data_d  = 8'h00;
                    done_d      = 1'b1;
                end else begin
                    state_d = ST_CSUM;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                out_data_d  = 8'h00;
            end
        endcase

        // A request that arrives mid-frame is dropped but remembered.
        if (trig && (state_q != ST_IDLE)) begin
            ovr_d = 1'b1;
        end else begin
            ovr_d = ovr_d;
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            snap_q      <= '0;
            idx_q       <= '0;
            csum_q      <= 8'h00;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            idx_q       <= idx_d;
            csum_q      <= csum_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ovr_q       <= ovr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ovr       = ovr_q;

endmodule

// File: tb/tb_dff_readback_framer.sv
module tb_dff_readback_framer;

    localparam int WIDTH = 64;
    localparam int NB    = WIDTH / 8;
    localparam int FLEN  = NB + 2;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] din;
    logic             trig;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic             ovr;

    int n_cmp;
    int n_fail;

    logic [7:0] got_q[$];
    logic       done_after;
    logic       timed_out;

    dff_readback_framer #(.WIDTH(WIDTH), .HEADER(8'hA5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .trig      (trig),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .ovr       (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Collect accepted bytes until one full frame is seen or the cycle budget runs out.
    // trig_at >= 0 pulses trig on that cycle. trig_at < 0 leaves trig as it is.
    task automatic collect(input int max_cyc, input bit toggle, input int trig_at);
        bit acc;
        got_q.delete();
        done_after = 1'b0;
        timed_out  = 1'b1;
        for (int c = 0; c < max_cyc; c++) begin
            out_ready = toggle ? ~c[0] : 1'b1;
            if (trig_at >= 0) trig = (c == trig_at);
            acc = out_valid && out_ready;
            if (acc) got_q.push_back(out_data);
            tick();
            if (acc && got_q.size() == FLEN) begin
                done_after = done;
                timed_out  = 1'b0;
                break;
            end
        end
        if (trig_at >= 0) trig = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; trig = 1'b0; out_ready = 1'b0; din = '0;
        tick(); tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", out_data); end
        n_cmp++; if ({busy, done, ovr} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {busy, done, ovr}); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_basic();
        logic [7:0] exp_b [FLEN];
        exp_b = '{8'hA5, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01, 8'h00};
        din = 64'h0123_4567_89AB_CDEF; trig = 1'b1; out_ready = 1'b1;
        tick();
        trig = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin n_fail++; $display("FAIL basic_latency got v=%b d=%h exp v=1 d=a5", out_valid, out_data); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b exp 1", busy); end
        collect(40, 1'b0, -1);
        n_cmp++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL basic_timeout got %0d bytes exp %0d", got_q.size(), FLEN); end
        for (int i = 0; i < FLEN; i++) begin
            n_cmp++; if (got_q[i] !== exp_b[i]) begin n_fail++; $display("FAIL basic_byte%0d got %h exp %h", i, got_q[i], exp_b[i]); end
        end
        n_cmp++; if (done_after !== 1'b1) begin n_fail++; $display("FAIL basic_done got %b exp 1", done_after); end
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00) begin n_fail++; $display("FAIL basic_end got v=%b b=%b d=%h exp 0 0 00", out_valid, busy, out_data); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b exp 0", done); end
    endtask

    task automatic test_stall();
        logic [7:0] exp_b [FLEN];
        logic [7:0] held;
        bit         stalled;
        int         hs;
        exp_b = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        din = 64'h1; trig = 1'b1; out_ready = 1'b0;
        tick();
        trig = 1'b0;
        got_q.delete();
        hs = 0; done_after = 1'b0; timed_out = 1'b1;
        for (int c = 0; c < 60; c++) begin
            out_ready = ~c[0];
            stalled = out_valid && !out_ready;
            held = out_data;
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                hs++;
            end
            tick();
            if (stalled) begin
                n_cmp++; if (out_valid !== 1'b1 || out_data !== held) begin n_fail++; $display("FAIL stall_hold c=%0d got v=%b d=%h exp v=1 d=%h", c, out_valid, out_data, held); end
            end
            if (hs == FLEN) begin
                done_after = done;
                timed_out = 1'b0;
                break;
            end
        end
        n_cmp++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL stall_handshakes got %0d exp %0d", hs, FLEN); end
        for (int i = 0; i < FLEN; i++) begin
            n_cmp++; if (got_q[i] !== exp_b[i]) begin n_fail++; $display("FAIL stall_byte%0d got %h exp %h", i, got_q[i], exp_b[i]); end
        end
        n_cmp++; if (done_after !== 1'b1) begin n_fail++; $display("FAIL stall_done got %b exp 1", done_after); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_snapshot();
        din = 64'hFFFF_FFFF_FFFF_FFFF; trig = 1'b1; out_ready = 1'b1;
        tick();
        trig = 1'b0; din = '0;
        collect(40, 1'b0, -1);
        n_cmp++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL snap_timeout got %0d bytes exp %0d", got_q.size(), FLEN); end
        n_cmp++; if (got_q[0] !== 8'hA5) begin n_fail++; $display("FAIL snap_hdr got %h exp a5", got_q[0]); end
        for (int i = 1; i <= NB; i++) begin
            n_cmp++; if (got_q[i] !== 8'hFF) begin n_fail++; $display("FAIL snap_byte%0d got %h exp ff", i, got_q[i]); end
        end
        n_cmp++; if (got_q[FLEN-1] !== 8'h00) begin n_fail++; $display("FAIL snap_csum got %h exp 00", got_q[FLEN-1]); end
        tick();
    endtask

    task automatic test_overrun();
        logic [7:0] exp_b [FLEN];
        exp_b = '{8'hA5, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01, 8'h00};
        din = 64'h0123_4567_89AB_CDEF; trig = 1'b1; out_ready = 1'b1;
        tick();
        trig = 1'b0;
        n_cmp++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_start got %b exp 0", ovr); end
        collect(40, 1'b0, 3);
        n_cmp++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL ovr_timeout got %0d bytes exp %0d", got_q.size(), FLEN); end
        for (int i = 0; i < FLEN; i++) begin
            n_cmp++; if (got_q[i] !== exp_b[i]) begin n_fail++; $display("FAIL ovr_byte%0d got %h exp %h", i, got_q[i], exp_b[i]); end
        end
        n_cmp++; if (ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_set got %b exp 1", ovr); end
        tick(); tick();
        n_cmp++; if (ovr !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL ovr_sticky got ovr=%b busy=%b exp 1 0", ovr, busy); end
        din = 64'h0; trig = 1'b1;
        tick();
        trig = 1'b0;
        n_cmp++; if (ovr !== 1'b0 || out_data !== 8'hA5) begin n_fail++; $display("FAIL ovr_clear got ovr=%b d=%h exp 0 a5", ovr, out_data); end
        collect(40, 1'b0, -1);
        n_cmp++; if (got_q.size() !== FLEN || got_q[FLEN-1] !== 8'h00) begin n_fail++; $display("FAIL ovr_drain got %0d bytes exp %0d", got_q.size(), FLEN); end
        tick();
    endtask

    task automatic test_midframe_reset();
        logic [7:0] exp_b [FLEN];
        exp_b = '{8'hA5, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'hFF};
        din = 64'h0123_4567_89AB_CDEF; trig = 1'b1; out_ready = 1'b1;
        tick();
        trig = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00) begin n_fail++; $display("FAIL rst_abort got v=%b b=%b d=%h exp 0 0 00", out_valid, busy, out_data); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_resume got %b exp 0", out_valid); end
        din = 64'h8040_2010_0804_0201; trig = 1'b1;
        tick();
        trig = 1'b0;
        collect(40, 1'b0, -1);
        n_cmp++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL rst_timeout got %0d bytes exp %0d", got_q.size(), FLEN); end
        for (int i = 0; i < FLEN; i++) begin
            n_cmp++; if (got_q[i] !== exp_b[i]) begin n_fail++; $display("FAIL rst_byte%0d got %h exp %h", i, got_q[i], exp_b[i]); end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [FLEN];
        exp_b = '{8'hA5, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01, 8'h00};
        din = 64'h0123_4567_89AB_CDEF; trig = 1'b1; out_ready = 1'b1;
        tick();
        collect(40, 1'b0, -1);
        n_cmp++; if (timed_out !== 1'b0 || done_after !== 1'b1) begin n_fail++; $display("FAIL b2b_frame1 got %0d bytes done=%b exp %0d 1", got_q.size(), done_after, FLEN); end
        for (int i = 0; i < FLEN; i++) begin
            n_cmp++; if (got_q[i] !== exp_b[i]) begin n_fail++; $display("FAIL b2b_f1_byte%0d got %h exp %h", i, got_q[i], exp_b[i]); end
        end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || done !== 1'b0 || ovr !== 1'b0) begin n_fail++; $display("FAIL b2b_restart got v=%b d=%h done=%b ovr=%b exp 1 a5 0 0", out_valid, out_data, done, ovr); end
        collect(40, 1'b0, -1);
        trig = 1'b0;
        n_cmp++; if (timed_out !== 1'b0 || done_after !== 1'b1) begin n_fail++; $display("FAIL b2b_frame2 got %0d bytes done=%b exp %0d 1", got_q.size(), done_after, FLEN); end
        for (int i = 0; i < FLEN; i++) begin
            n_cmp++; if (got_q[i] !== exp_b[i]) begin n_fail++; $display("FAIL b2b_f2_byte%0d got %h exp %h", i, got_q[i], exp_b[i]); end
        end
        tick();
        n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got b=%b v=%b exp 0 0", busy, out_valid); end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst_n = 1'b0; trig = 1'b0; out_ready = 1'b0; din = '0;
        test_reset();
        test_basic();
        test_stall();
        test_snapshot();
        test_overrun();
        test_midframe_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
